// File: rtl/rx_block_lock_if.sv
// Receive block-lock bus: gearbox header/valid stream in, lock/slip status out.
interface rx_block_lock_if #(
    parameter int CNT_WIDTH = 8
);
    logic [1:0]           i_rx_header;
    logic                 i_rx_header_valid;
    logic                 i_rx_data_valid;
    logic                 o_block_lock;
    logic                 o_slip;
    logic [CNT_WIDTH-1:0] o_slip_count;
    logic [CNT_WIDTH-1:0] o_lock_loss_count;

    // Gearbox side: drives headers, consumes slip/lock status.
    modport master (
        output i_rx_header, i_rx_header_valid, i_rx_data_valid,
        input  o_block_lock, o_slip, o_slip_count, o_lock_loss_count
    );

    // Block-lock FSM side.
    modport slave (
        input  i_rx_header, i_rx_header_valid, i_rx_data_valid,
        output o_block_lock, o_slip, o_slip_count, o_lock_loss_count
    );
endinterface

// File: rtl/rx_block_lock.sv
// 64b66b receive block-synchronisation FSM for a 32-bit gearbox datapath.
// Watches the sync header of every header event, asserts block lock after a
// clean window and requests single-cycle bit slips while searching.
module rx_block_lock #(
    parameter int SH_CNT_MAX   = 64,
    parameter int SH_INVLD_MAX = 16,
    parameter int SLIP_WAIT    = 32,
    parameter int CNT_WIDTH    = 8
) (
    input  logic          i_rxc,
    input  logic          i_reset_n,
    rx_block_lock_if.slave io_rx
);
    localparam int SH_W = $clog2(SH_CNT_MAX + 1);
    localparam int IV_W = $clog2(SH_INVLD_MAX + 1);
    localparam int WT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_LOCK_INIT = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    state_t               r_state,      w_state_nxt;
    logic [SH_W-1:0]      r_sh_cnt,     w_sh_cnt_nxt;
    logic [IV_W-1:0]      r_invld_cnt,  w_invld_cnt_nxt;
    logic [WT_W-1:0]      r_wait_cnt,   w_wait_cnt_nxt;
    logic                 r_lock,       w_lock_nxt;
    logic                 r_slip,       w_slip_nxt;
    logic [CNT_WIDTH-1:0] r_slip_cnt,   w_slip_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_loss_cnt,   w_loss_cnt_nxt;

    logic                 w_event;
    logic                 w_invalid;
    logic [SH_W-1:0]      w_new_cnt;
    logic [IV_W-1:0]      w_new_invld;

    // A header only counts when the gearbox is not pausing; 00/11 are illegal headers.
    assign w_event     = io_rx.i_rx_header_valid && io_rx.i_rx_data_valid;
    assign w_invalid   = (io_rx.i_rx_header == 2'b00) || (io_rx.i_rx_header == 2'b11);
    assign w_new_cnt   = r_sh_cnt + SH_W'(1);
    assign w_new_invld = r_invld_cnt + (w_invalid ? IV_W'(1) : IV_W'(0));

    // State register and all registered outputs, synchronous active-low reset.
    always_ff @(posedge i_rxc) begin
        if (!i_reset_n) begin
            r_state     <= ST_LOCK_INIT;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_wait_cnt  <= '0;
            r_lock      <= 1'b0;
            r_slip      <= 1'b0;
            r_slip_cnt  <= '0;
            r_loss_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sh_cnt    <= w_sh_cnt_nxt;
            r_invld_cnt <= w_invld_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_lock      <= w_lock_nxt;
            r_slip      <= w_slip_nxt;
            r_slip_cnt  <= w_slip_cnt_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
        end
    end

    // Next-state and next-output logic; slip is a pulse so it defaults low.
    always_comb begin
        w_state_nxt     = r_state;
        w_sh_cnt_nxt    = r_sh_cnt;
        w_invld_cnt_nxt = r_invld_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_lock_nxt      = r_lock;
        w_slip_nxt      = 1'b0;
        w_slip_cnt_nxt  = r_slip_cnt;
        w_loss_cnt_nxt  = r_loss_cnt;

        case (r_state)
            ST_LOCK_INIT: begin
                w_sh_cnt_nxt    = '0;
                w_invld_cnt_nxt = '0;
                w_wait_cnt_nxt  = '0;
                w_state_nxt     = ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (w_event) begin
                    if (w_invalid && (!r_lock || w_new_invld == IV_W'(SH_INVLD_MAX))) begin
                        // Misaligned: request a slip and drop lock.
                        w_slip_nxt      = 1'b1;
                        w_lock_nxt      = 1'b0;
                        w_slip_cnt_nxt  = r_slip_cnt + CNT_WIDTH'(1);
                        if (r_lock && (r_loss_cnt != '1))
                            w_loss_cnt_nxt = r_loss_cnt + CNT_WIDTH'(1);
                        w_sh_cnt_nxt    = '0;
                        w_invld_cnt_nxt = '0;
                        w_wait_cnt_nxt  = '0;
                        w_state_nxt     = ST_SLIP_WAIT;
                    end else if (w_new_cnt == SH_W'(SH_CNT_MAX)) begin
                        // End of window: a fully clean window grants lock.
                        if (w_new_invld == '0)
                            w_lock_nxt = 1'b1;
                        w_sh_cnt_nxt    = '0;
                        w_invld_cnt_nxt = '0;
                    end else begin
                        w_sh_cnt_nxt    = w_new_cnt;
                        w_invld_cnt_nxt = w_new_invld;
                    end
                end
            end
            ST_SLIP_WAIT: begin
                // Headers are meaningless until the gearbox has realigned.
                if (w_event) begin
                    if (r_wait_cnt == WT_W'(SLIP_WAIT - 1)) begin
                        w_wait_cnt_nxt  = '0;
                        w_sh_cnt_nxt    = '0;
                        w_invld_cnt_nxt = '0;
                        w_state_nxt     = ST_TEST_SH;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_LOCK_INIT;
        endcase
    end

    assign io_rx.o_block_lock      = r_lock;
    assign io_rx.o_slip            = r_slip;
    assign io_rx.o_slip_count      = r_slip_cnt;
    assign io_rx.o_lock_loss_count = r_loss_cnt;
endmodule

// File: tb/tb_rx_block_lock.sv
// Scoreboard bench for rx_block_lock: a reference model predicts the
// registered outputs for every driven cycle; predictions are queued and
// compared against the DUT just after the following clock edge.
module tb_rx_block_lock;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rx_block_lock_if #(.CNT_WIDTH(8)) bus ();

    rx_block_lock #(
        .SH_CNT_MAX   (64),
        .SH_INVLD_MAX (16),
        .SLIP_WAIT    (32),
        .CNT_WIDTH    (8)
    ) dut (
        .i_rxc     (clk),
        .i_reset_n (rst_n),
        .io_rx     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lock;
        int slip;
        int scnt;
        int lcnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int m_state = 0;   // 0 init, 1 test, 2 wait
    int m_cnt = 0, m_inv = 0, m_wait = 0;
    int m_lock = 0, m_slip = 0, m_scnt = 0, m_lcnt = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic hv, input logic dv, input logic [1:0] h);
        int nc, ni;
        bit ev, bad;
        ev  = hv && dv;
        bad = (h == 2'b00) || (h == 2'b11);
        if (!rn) begin
            m_state = 0; m_cnt = 0; m_inv = 0; m_wait = 0;
            m_lock = 0; m_slip = 0; m_scnt = 0; m_lcnt = 0;
        end else begin
            m_slip = 0;
            if (m_state == 0) begin
                m_cnt = 0; m_inv = 0; m_wait = 0;
                m_state = 1;
            end else if (m_state == 1) begin
                if (ev) begin
                    nc = m_cnt + 1;
                    ni = m_inv + (bad ? 1 : 0);
                    if (bad && (m_lock == 0 || ni == 16)) begin
                        m_slip = 1;
                        if (m_lock == 1 && m_lcnt < 255) m_lcnt++;
                        m_lock = 0;
                        m_scnt = (m_scnt + 1) % 256;
                        m_cnt = 0; m_inv = 0; m_wait = 0;
                        m_state = 2;
                    end else if (nc == 64) begin
                        if (ni == 0) m_lock = 1;
                        m_cnt = 0; m_inv = 0;
                    end else begin
                        m_cnt = nc; m_inv = ni;
                    end
                end
            end else begin
                if (ev) begin
                    m_wait++;
                    if (m_wait == 32) begin
                        m_wait = 0; m_cnt = 0; m_inv = 0;
                        m_state = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, predict, then compare just after posedge.
    task automatic step(input logic rn, input logic hv, input logic dv, input logic [1:0] h);
        exp_t e;
        @(negedge clk);
        rst_n                 = rn;
        bus.i_rx_header_valid = hv;
        bus.i_rx_data_valid   = dv;
        bus.i_rx_header       = h;
        model_step(rn, hv, dv, h);
        e.lock = m_lock; e.slip = m_slip; e.scnt = m_scnt; e.lcnt = m_lcnt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            check("lock", int'(bus.o_block_lock), e.lock);
            check("slip", int'(bus.o_slip), e.slip);
            check("slip_cnt", int'(bus.o_slip_count), e.scnt);
            check("loss_cnt", int'(bus.o_lock_loss_count), e.lcnt);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 2'b01);
        step(1'b0, 1'b0, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b0, 2'b01);
    endtask

    task automatic valid_events(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    endtask

    initial begin
        logic [1:0] h;
        int inv_left;
        bus.i_rx_header       = 2'b01;
        bus.i_rx_header_valid = 1'b0;
        bus.i_rx_data_valid   = 1'b0;

        // Reset state
        do_reset();
        check("rst_lock", int'(bus.o_block_lock), 0);
        check("rst_slip_cnt", int'(bus.o_slip_count), 0);

        // Acquire lock with pause cycles sprinkled between events
        for (int i = 0; i < 64; i++) begin
            if (i % 7 == 3) step(1'b1, 1'b1, 1'b0, 2'b11);
            step(1'b1, 1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        check("lock_after_64", int'(bus.o_block_lock), 1);
        check("no_slip_acquire", int'(bus.o_slip_count), 0);

        // Unlocked slip and SLIP_WAIT spacing
        do_reset();
        valid_events(10);
        step(1'b1, 1'b1, 1'b1, 2'b00);
        check("first_slip", int'(bus.o_slip), 1);
        check("slip_cnt_1", int'(bus.o_slip_count), 1);
        for (int i = 0; i < 32; i++) step(1'b1, 1'b1, 1'b1, 2'b00);
        check("wait_no_slip", int'(bus.o_slip_count), 1);
        step(1'b1, 1'b1, 1'b1, 2'b11);
        check("second_slip", int'(bus.o_slip), 1);
        check("slip_cnt_2", int'(bus.o_slip_count), 2);

        // Locked: 15 invalid in a window tolerated, then 16 drop lock
        do_reset();
        valid_events(64);
        inv_left = 15;
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 1 && inv_left > 0) begin
                step(1'b1, 1'b1, 1'b1, (inv_left % 2 == 0) ? 2'b00 : 2'b11);
                inv_left--;
            end else begin
                step(1'b1, 1'b1, 1'b1, 2'b10);
            end
        end
        check("lock_held_15", int'(bus.o_block_lock), 1);
        valid_events(64);
        check("lock_clean_window", int'(bus.o_block_lock), 1);
        inv_left = 16;
        for (int i = 0; i < 64 && inv_left > 0; i++) begin
            if (i % 3 == 0) begin
                step(1'b1, 1'b1, 1'b1, 2'b00);
                inv_left--;
            end else begin
                step(1'b1, 1'b1, 1'b1, 2'b01);
            end
        end
        check("lock_lost_16", int'(bus.o_block_lock), 0);
        check("slip_on_loss", int'(bus.o_slip), 1);
        check("loss_cnt_1", int'(bus.o_lock_loss_count), 1);
        check("slip_cnt_loss", int'(bus.o_slip_count), 1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)));

        // Header valid without data valid is ignored
        do_reset();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 2'b11);
        check("paused_no_slip", int'(bus.o_slip_count), 0);
        valid_events(64);
        check("lock_after_pause", int'(bus.o_block_lock), 1);

        // Reset while slip is high, then relock from scratch
        do_reset();
        step(1'b1, 1'b1, 1'b1, 2'b00);
        step(1'b0, 1'b1, 1'b1, 2'b01);
        check("rst_mid_slip", int'(bus.o_slip), 0);
        check("rst_mid_scnt", int'(bus.o_slip_count), 0);
        step(1'b1, 1'b0, 1'b0, 2'b01);
        valid_events(63);
        check("no_lock_63", int'(bus.o_block_lock), 0);
        valid_events(1);
        check("relock_64", int'(bus.o_block_lock), 1);

        // Randomised traffic with occasional reset
        do_reset();
        for (int i = 0; i < 600; i++) begin
            h = ($urandom_range(0, 99) < 93) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 1) * 3);
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 9) != 0), h);
        end

        // Repeated lock loss: loss counter saturates, slip counter wraps
        do_reset();
        for (int k = 0; k < 260; k++) begin
            valid_events(64);
            for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 2'b11);
            valid_events(32);
        end
        check("loss_saturated", int'(bus.o_lock_loss_count), 255);
        check("slip_wrapped", int'(bus.o_slip_count), 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
